// File: rtl/rtc_bus_if.sv
// rtc_bus_if: multiplexed RTC parallel bus between the access sequencer
// (master) and the register responder (slave).
//   cs_n, rd_n, wr_n : active-low chip select / read / write strobes
//   a_d              : phase select, 0 = address phase, 1 = data phase
//   ad_in            : AD bus value driven by the initiator
//   ad_out, ad_oe    : read data and its drive enable (tristate built at top)
//   addr_q           : currently latched address (debug)
//   wr_pulse         : one-clock pulse when a register write commits
//   proto_err        : one-clock pulse on an illegal strobe combination
interface rtc_bus_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] addr_q;
  logic       wr_pulse;
  logic       proto_err;

  modport master (
    output cs_n, rd_n, wr_n, a_d, ad_in,
    input  ad_out, ad_oe, addr_q, wr_pulse, proto_err
  );

  modport slave (
    input  cs_n, rd_n, wr_n, a_d, ad_in,
    output ad_out, ad_oe, addr_q, wr_pulse, proto_err
  );
endinterface

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: on-chip RTC stand-in answering the multiplexed RTC bus.
// Holds a 16-byte register file, decodes address/data phases and returns read
// data on a split AD bus.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : rtc_bus_if.slave (strobes, AD bus, read data, debug/status pulses)
// Parameters:
//   TICK_DIV : clocks per emulated second (only used with RTC_TIME_EN), >= 2
//   NREGS    : number of registers, fixed at 16
// Build option:
//   RTC_TIME_EN : when defined, registers 0x00/0x01/0x02 become BCD
//                 seconds/minutes/hours advanced every TICK_DIV clocks.
module rtc_bus_responder #(
  parameter int TICK_DIV = 100_000_000,
  parameter int NREGS    = 16
) (
  input  logic     clk,
  input  logic     reset,
  rtc_bus_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

  state_t     state;
  logic       cs_q, rd_q, wr_q;
  logic       ill_q;
  logic [7:0] cap;
  logic [7:0] regs [NREGS];

  logic       wr_edge;
  logic       illegal;
  logic       in_range;
  logic [7:0] rd_val;

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("rtc_bus_responder: TICK_DIV must be 2 or more");
  end

  // Write commits on the rising edge of wr_n while the chip was selected.
  assign wr_edge  = !wr_q && bus.wr_n && !cs_q;
  assign illegal  = !bus.cs_n && !bus.rd_n && !bus.wr_n;
  assign in_range = (bus.addr_q[7:4] == 4'h0);
  assign rd_val   = in_range ? regs[bus.addr_q[3:0]] : 8'h00;

`ifdef RTC_TIME_EN
  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             sec_wrap, min_wrap;
  logic [7:0]       sec_nx, min_nx, hr_nx;

  // Valid BCD digits carry 9 -> 0 into the tens digit; anything else
  // (including non-BCD values written by software) simply counts up by one.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)
      return 8'h00;
    else if (v[3:0] == 4'h9 && v[7:4] <= 4'h9)
      return {v[7:4] + 4'h1, 4'h0};
    else
      return v + 8'h01;
  endfunction

  assign tick     = (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign sec_wrap = (regs[0] == 8'h59);
  assign min_wrap = (regs[1] == 8'h59);
  assign sec_nx   = bcd_inc(regs[0], 8'h59);
  assign min_nx   = bcd_inc(regs[1], 8'h59);
  assign hr_nx    = bcd_inc(regs[2], 8'h23);

  always_ff @(posedge clk) begin
    if (!reset)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cs_q          <= 1'b1;
      rd_q          <= 1'b1;
      wr_q          <= 1'b1;
      ill_q         <= 1'b0;
      cap           <= 8'h00;
      bus.ad_out    <= 8'h00;
      bus.ad_oe     <= 1'b0;
      bus.addr_q    <= 8'h00;
      bus.wr_pulse  <= 1'b0;
      bus.proto_err <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      cs_q          <= bus.cs_n;
      rd_q          <= bus.rd_n;
      wr_q          <= bus.wr_n;
      ill_q         <= illegal;
      bus.wr_pulse  <= 1'b0;
      // Pulse once per illegal episode, even if the initiator holds it.
      bus.proto_err <= illegal && !ill_q;
      // Capture register tracks the last value seen while wr_n is low.
      if (!bus.cs_n && !bus.wr_n) cap <= bus.ad_in;

`ifdef RTC_TIME_EN
      // Timekeeping first; a bus write later in this block overrides the
      // same register, while the carry into higher registers still lands.
      if (tick) begin
        regs[0] <= sec_nx;
        if (sec_wrap) begin
          regs[1] <= min_nx;
          if (min_wrap) regs[2] <= hr_nx;
        end
      end
`endif

      if (illegal) begin
        state      <= IDLE;
        bus.ad_oe  <= 1'b0;
        bus.ad_out <= 8'h00;
      end else begin
        case (state)
          IDLE: begin
            bus.ad_oe  <= 1'b0;
            bus.ad_out <= 8'h00;
            // Phase is fixed here; later a_d changes are ignored.
            if (!bus.cs_n && !bus.wr_n) begin
              state <= bus.a_d ? WDATA : ADDR;
            end else if (!bus.cs_n && !bus.rd_n && bus.a_d) begin
              state      <= RDATA;
              bus.ad_oe  <= 1'b1;
              bus.ad_out <= rd_val;
            end
          end
          ADDR: begin
            if (wr_edge) begin
              bus.addr_q <= cap;
              state      <= IDLE;
            end else if (bus.cs_n) begin
              state <= IDLE;
            end
          end
          WDATA: begin
            if (wr_edge) begin
              if (in_range) regs[bus.addr_q[3:0]] <= cap;
              bus.wr_pulse <= 1'b1;
              state        <= IDLE;
            end else if (bus.cs_n) begin
              state <= IDLE;
            end
          end
          RDATA: begin
            if (bus.rd_n || bus.cs_n) begin
              state      <= IDLE;
              bus.ad_oe  <= 1'b0;
              bus.ad_out <= 8'h00;
            end else begin
              bus.ad_oe  <= 1'b1;
              bus.ad_out <= rd_val;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
